pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Generates the fetch address and the fetch/decode strobes for the front end.
// A fetch is issued on every rising edge where every execution unit is empty
// and there is neither an unresolved branch nor a pending store. A redirect
// (pcChange) loads a new aligned target. The next fetch then uses that
// target without first adding STEP to it.
//
// Parameters
//   XLEN      width of pc and changeData
//   NUM_UNITS number of execution-unit empty flags
//   STEP      pc increment per fetch (power of two)
//   RESET_PC  address of the first fetch after reset
//
// Ports
//   clock        single clock, rising-edge active
//   reset        asynchronous, active-high
//   unitEmpty    per-unit empty flags (1 = unit can accept work)
//   nobranch     no unresolved branch in flight
//   nostore      no pending store
//   pcChange     redirect request, sampled at each rising edge
//   changeData   redirect target, valid while pcChange=1
//   available    registered all-clear status
//   pc           current fetch address
//   fetchPulse   one-cycle fetch strobe for the address on pc
//   decodePulse  fetchPulse delayed by one cycle
//
// Build option
//   PC_REDIRECT_FLUSH_EN  when defined, a redirect that arrives in the same
//                         cycle as a fetch strobe squashes the decode strobe
//                         that would otherwise follow it.
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_UNITS = 5,
  parameter int unsigned STEP      = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] unitEmpty,
  input  logic                 nobranch,
  input  logic                 nostore,
  input  logic                 pcChange,
  input  logic [XLEN-1:0]      changeData,
  output logic                 available,
  output logic [XLEN-1:0]      pc,
  output logic                 fetchPulse,
  output logic                 decodePulse
);

  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  // Clears the low log2(STEP) bits of a redirect target.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP_V - 1'b1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    TARGET = 2'd2
  } state_t;

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic            available_reg;
  logic            fetch_reg;
  logic            decode_reg;

  logic all_clear;
  logic squash;

  // Each unit flag is folded into a running AND chain.
  logic [NUM_UNITS:0] unit_chain;
  assign unit_chain[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_units
      assign unit_chain[gi+1] = unit_chain[gi] & unitEmpty[gi];
    end
  endgenerate

  assign all_clear = unit_chain[NUM_UNITS] & nobranch & nostore;

`ifdef PC_REDIRECT_FLUSH_EN
  // A redirect seen while fetchPulse is high means the fetched instruction
  // is on the wrong path, so it must not be decoded.
  assign squash = pcChange;
`else
  assign squash = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      // One step behind RESET_PC, so the first increment lands on it.
      pc_reg        <= RESET_PC - STEP_V;
      available_reg <= 1'b0;
      fetch_reg     <= 1'b0;
      decode_reg    <= 1'b0;
    end else begin
      available_reg <= all_clear;
      decode_reg    <= fetch_reg & ~squash;
      if (pcChange) begin
        // A redirect wins over an increment, whatever allClear says.
        pc_reg    <= changeData & ALIGN_MASK;
        fetch_reg <= 1'b0;
        state_reg <= TARGET;
      end else if (all_clear) begin
        // After a redirect the target itself is fetched, not target+STEP.
        if (state_reg != TARGET) begin
          pc_reg <= pc_reg + STEP_V;
        end
        fetch_reg <= 1'b1;
        state_reg <= RUN;
      end else begin
        fetch_reg <= 1'b0;
        if (state_reg == RUN) begin
          state_reg <= IDLE;
        end
      end
    end
  end

  assign available   = available_reg;
  assign pc          = pc_reg;
  assign fetchPulse  = fetch_reg;
  assign decodePulse = decode_reg;

endmodule
